// File: rtl/ahb_mem_responder_pkg.sv
// ahb_mem_responder_pkg: AHB-Lite transfer/burst encodings, response constants and responder FSM states.
package ahb_mem_responder_pkg;
    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_t;

    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_WRAP4  = 3'b010;
    localparam logic [2:0] BURST_INCR4  = 3'b011;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    typedef enum logic [2:0] {IDLE_S, WAIT_S, DATA_S, ERR1_S, ERR2_S} resp_state_t;
endpackage

// File: rtl/ahb_mem_responder_burst_addr_next.sv
// ahb_burst_addr_next: next expected beat address of a WRAP4 (16-byte wrap) or incrementing burst.
module ahb_burst_addr_next
    import ahb_mem_responder_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  hburst,
    output logic [31:0] next_addr
);
    always_comb next_addr = (hburst == BURST_WRAP4) ? {addr[31:4], addr[3:2] + 2'd1, addr[1:0]} : addr + 32'd4;
endmodule

// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-Lite word memory slave with wait states, burst address checking and backdoor preload.
// Define AHB_MEM_ERR_RESP_EN to answer out-of-range addresses with a two-cycle ERROR instead of wrapping.
module ahb_mem_responder
    import ahb_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                         hclk,
    input  logic                         hrstn,
    input  logic                         hsel,
    input  logic [31:0]                  haddr,
    input  logic                         hwrite,
    input  logic [1:0]                   htrans,
    input  logic [2:0]                   hburst,
    input  logic [2:0]                   hsize,
    input  logic [31:0]                  hwdata,
    output logic                         hready,
    output logic [31:0]                  hrdata,
    output logic                         hresp,
    output logic                         proto_err,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
    input  logic [31:0]                  bd_wdata
);
    localparam int         AW = $clog2(MEM_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    resp_state_t   state, state_d;
    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   off, exp_addr, nxt_in, nxt_addr, rdata, fwd;
    logic [AW-1:0] acc_idx, idx, rd_idx;
    logic [3:0]    wcnt;
    logic [1:0]    beats;
    logic [2:0]    nxt_burst;
    logic          burst_wrap, wr, acc, nonseq, seq, oor, err_now, rd_load, unused_off;

    assign off        = haddr - BASE_ADDR;
    assign acc_idx    = off[AW+1:2];
    assign unused_off = ^off;
    assign nonseq     = htrans == TRANS_NONSEQ;
    assign seq        = htrans == TRANS_SEQ;
    assign hready     = (state != WAIT_S) && (state != ERR1_S);
    assign acc        = hsel && hready && (nonseq || seq) && (state != ERR2_S);
    assign hrdata     = rdata;
`ifdef AHB_MEM_ERR_RESP_EN
    assign oor   = off >= 32'(MEM_WORDS * 4);
    assign hresp = (state == ERR1_S || state == ERR2_S) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign oor   = 1'b0;
    assign hresp = HRESP_OKAY;
`endif

    always_comb begin
        state_d = IDLE_S;
        if (acc) state_d = oor ? ERR1_S : ((WS != 4'd0) ? WAIT_S : DATA_S);
        if (state == WAIT_S) state_d = (wcnt == 4'd1) ? DATA_S : WAIT_S;
        if (state == ERR1_S) state_d = ERR2_S;
    end

    // A zero-wait read follows a write to the same word in the write's own data phase, so forward hwdata.
    assign rd_idx  = (state == WAIT_S) ? idx : acc_idx;
    assign rd_load = (state_d == DATA_S) && ((state == WAIT_S) ? !wr : !hwrite);
    assign fwd     = (state == DATA_S && wr && idx == rd_idx) ? hwdata : mem[rd_idx];

    assign err_now = acc && ((seq && (beats == 2'd0 || haddr != exp_addr)) || (nonseq && beats != 2'd0) ||
                             hsize != HSIZE_WORD || haddr[1:0] != 2'b00);
    assign nxt_in    = nonseq ? haddr : exp_addr;
    assign nxt_burst = nonseq ? hburst : (burst_wrap ? BURST_WRAP4 : BURST_INCR4);

    ahb_burst_addr_next u_next (.addr(nxt_in), .hburst(nxt_burst), .next_addr(nxt_addr));

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state      <= IDLE_S;
            wcnt       <= 4'd0;
            idx        <= '0;
            wr         <= 1'b0;
            rdata      <= 32'h0;
            beats      <= 2'd0;
            exp_addr   <= 32'h0;
            burst_wrap <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state <= state_d;
            wcnt  <= (state == WAIT_S) ? wcnt - 4'd1 : WS;
            if (acc) begin
                idx <= acc_idx;
                wr  <= hwrite;
            end
            if (rd_load) rdata <= fwd;
            if (err_now) proto_err <= 1'b1;
            if (acc && nonseq) begin
                beats      <= (hburst == BURST_WRAP4 || hburst == BURST_INCR4) ? 2'd3 : 2'd0;
                burst_wrap <= hburst == BURST_WRAP4;
                exp_addr   <= nxt_addr;
            end else if (acc && seq) begin
                beats    <= (beats != 2'd0) ? beats - 2'd1 : 2'd0;
                exp_addr <= nxt_addr;
            end
        end
    end

    // The AHB write is placed last so it overrides a same-cycle backdoor write to the same word.
    always_ff @(posedge hclk) begin
        if (bd_we) mem[bd_addr] <= bd_wdata;
        if (hrstn && state == DATA_S && wr) mem[idx] <= hwdata;
    end
endmodule
